// File: rtl/fwd_hazard_if.sv
// Bundle of decode/execute/writeback hazard signals shared between the pipeline
// control and the forwarding/hazard unit.
interface fwd_hazard_if #(
  parameter int RW    = 5,
  parameter int CNT_W = 16
);
  logic [RW-1:0]    in_ifid_rs1;
  logic [RW-1:0]    in_ifid_rs2;
  logic             in_ifid_use_rs1;
  logic             in_ifid_use_rs2;
  logic             in_ifid_is_mc;
  logic [RW-1:0]    in_idex_rs1;
  logic [RW-1:0]    in_idex_rs2;
  logic [RW-1:0]    in_idex_rd;
  logic             in_idex_use_rs1;
  logic             in_idex_use_rs2;
  logic             in_idex_is_store;
  logic             in_idex_memread;
  logic             in_idex_regwrite;
  logic             in_exmem_regwrite;
  logic             in_memwb_regwrite;
  logic [RW-1:0]    in_exmem_rd;
  logic [RW-1:0]    in_memwb_rd;
  logic             in_mc_issue;
  logic [RW-1:0]    in_mc_rd;
  logic             in_mc_done;
  logic [RW-1:0]    in_mc_done_rd;
  logic [1:0]       out_forwarda_sel;
  logic [1:0]       out_forwardb_sel;
  logic [1:0]       out_forwardwd_sel;
  logic             out_stall;
  logic             out_idex_bubble;
  logic             out_mc_full;
  logic [CNT_W-1:0] out_stall_count;

  modport master (
    output in_ifid_rs1, in_ifid_rs2, in_ifid_use_rs1, in_ifid_use_rs2, in_ifid_is_mc,
           in_idex_rs1, in_idex_rs2, in_idex_rd, in_idex_use_rs1, in_idex_use_rs2,
           in_idex_is_store, in_idex_memread, in_idex_regwrite,
           in_exmem_regwrite, in_memwb_regwrite, in_exmem_rd, in_memwb_rd,
           in_mc_issue, in_mc_rd, in_mc_done, in_mc_done_rd,
    input  out_forwarda_sel, out_forwardb_sel, out_forwardwd_sel,
           out_stall, out_idex_bubble, out_mc_full, out_stall_count
  );

  modport slave (
    input  in_ifid_rs1, in_ifid_rs2, in_ifid_use_rs1, in_ifid_use_rs2, in_ifid_is_mc,
           in_idex_rs1, in_idex_rs2, in_idex_rd, in_idex_use_rs1, in_idex_use_rs2,
           in_idex_is_store, in_idex_memread, in_idex_regwrite,
           in_exmem_regwrite, in_memwb_regwrite, in_exmem_rd, in_memwb_rd,
           in_mc_issue, in_mc_rd, in_mc_done, in_mc_done_rd,
    output out_forwarda_sel, out_forwardb_sel, out_forwardwd_sel,
           out_stall, out_idex_bubble, out_mc_full, out_stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall sequencing and a pending-write scoreboard
// for multi-cycle units, plus a saturating stalled-cycle counter.
module fwd_hazard_unit #(
  parameter int RW       = 5,
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);
  localparam int         OCW     = $clog2(MAX_OUT + 1);
  localparam int         NADDR   = 2 ** RW;
  localparam logic [RW:0] NREGS_W = (RW + 1)'(NREGS);

  typedef enum logic {IDLE, LU_WAIT} lu_state_t;

  lu_state_t        state_reg, state_next;
  logic [2:0]       lu_cnt_reg, lu_cnt_next;
  logic [NREGS-1:0] pend_reg, pend_next;
  logic [NADDR-1:0] pend_ext;
  logic [OCW-1:0]   out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [1:0] rs1_sel, rs2_sel;
  logic       load_use, lu_stall, sb_stall, stall, mc_full;
  logic       issue_ok, done_ok;

  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] src, input logic use_src,
    input logic ex_rw, input logic [RW-1:0] ex_rd,
    input logic wb_rw, input logic [RW-1:0] wb_rd
  );
    if (use_src && ex_rw && ex_rd != '0 && ex_rd == src)      return 2'b10;
    else if (use_src && wb_rw && wb_rd != '0 && wb_rd == src) return 2'b01;
    else                                                      return 2'b00;
  endfunction

  assign rs1_sel = fwd_sel(bus.in_idex_rs1, bus.in_idex_use_rs1,
                           bus.in_exmem_regwrite, bus.in_exmem_rd,
                           bus.in_memwb_regwrite, bus.in_memwb_rd);
  assign rs2_sel = fwd_sel(bus.in_idex_rs2, bus.in_idex_use_rs2,
                           bus.in_exmem_regwrite, bus.in_exmem_rd,
                           bus.in_memwb_regwrite, bus.in_memwb_rd);

  // Stores consume rs2 as write data, so its forward goes to the data mux instead.
  assign bus.out_forwarda_sel  = rs1_sel;
  assign bus.out_forwardb_sel  = bus.in_idex_is_store ? 2'b00 : rs2_sel;
  assign bus.out_forwardwd_sel = bus.in_idex_is_store ? rs2_sel : 2'b00;

  assign load_use = bus.in_idex_memread & bus.in_idex_regwrite & (bus.in_idex_rd != '0) &
                    ((bus.in_ifid_use_rs1 & (bus.in_ifid_rs1 == bus.in_idex_rd)) |
                     (bus.in_ifid_use_rs2 & (bus.in_ifid_rs2 == bus.in_idex_rd)));

  // Full address-space view of the scoreboard; registers beyond NREGS read as idle.
  for (genvar gi = 0; gi < NADDR; gi++) begin : g_pend_ext
    if (gi < NREGS) begin : g_map
      assign pend_ext[gi] = pend_reg[gi];
    end else begin : g_zero
      assign pend_ext[gi] = 1'b0;
    end
  end

  assign mc_full  = (out_cnt_reg == OCW'(MAX_OUT));
  assign issue_ok = bus.in_mc_issue & (bus.in_mc_rd != '0) & ({1'b0, bus.in_mc_rd} < NREGS_W) & ~mc_full;
  assign done_ok  = bus.in_mc_done & pend_ext[bus.in_mc_done_rd];

  // Set wins over clear so a same-cycle issue/done on one register keeps it pending.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend_next
    if (gi == 0) begin : g_x0
      assign pend_next[gi] = 1'b0;
    end else begin : g_reg
      assign pend_next[gi] = (issue_ok & (bus.in_mc_rd == RW'(gi))) |
                             (pend_reg[gi] & ~(done_ok & (bus.in_mc_done_rd == RW'(gi))));
    end
  end

  always_comb begin
    out_cnt_next = out_cnt_reg;
    case ({issue_ok, done_ok})
      2'b10:   out_cnt_next = out_cnt_reg + OCW'(1);
      2'b01:   out_cnt_next = out_cnt_reg - OCW'(1);
      default: out_cnt_next = out_cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lu_cnt_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      lu_cnt_reg <= lu_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    lu_cnt_next = lu_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load_use && LOAD_LAT > 1) begin
          state_next  = LU_WAIT;
          lu_cnt_next = 3'(LOAD_LAT - 1);
        end
      end
      LU_WAIT: begin
        lu_cnt_next = lu_cnt_reg - 3'd1;
        if (lu_cnt_reg == 3'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lu_stall = 1'b0;
    case (state_reg)
      IDLE:    lu_stall = load_use;
      LU_WAIT: lu_stall = 1'b1;
      default: lu_stall = 1'b0;
    endcase
  end

  assign sb_stall = (bus.in_ifid_use_rs1 & pend_ext[bus.in_ifid_rs1]) |
                    (bus.in_ifid_use_rs2 & pend_ext[bus.in_ifid_rs2]) |
                    (bus.in_ifid_is_mc & mc_full);
  assign stall    = lu_stall | sb_stall;

  assign bus.out_stall       = stall;
  assign bus.out_idex_bubble = stall;
  assign bus.out_mc_full     = mc_full;
  assign bus.out_stall_count = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg      <= '0;
      out_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      pend_reg    <= pend_next;
      out_cnt_reg <= out_cnt_next;
      if (stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a behavioural
// model and queues them; a negedge monitor compares against the unit.
module tb_fwd_hazard_unit;
  localparam int RW       = 5;
  localparam int NREGS    = 32;
  localparam int LOAD_LAT = 3;
  localparam int MAX_OUT  = 2;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  fwd_hazard_if #(.RW(RW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(
    .RW(RW), .NREGS(NREGS), .LOAD_LAT(LOAD_LAT), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fa;
    int fb;
    int fwd;
    int stall;
    int bubble;
    int full;
    int cnt;
    bit chk_state;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  // Behavioural model: remaining load-use stall cycles, pending set, op count.
  bit m_pend[NREGS];
  int m_out     = 0;
  int m_lu_left = 0;
  int m_cnt     = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: txn %0d got %0d expected %0d", name, txn, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("forwarda_sel",  int'(bus.out_forwarda_sel),  mon_e.fa);
      chk("forwardb_sel",  int'(bus.out_forwardb_sel),  mon_e.fb);
      chk("forwardwd_sel", int'(bus.out_forwardwd_sel), mon_e.fwd);
      if (mon_e.chk_state) begin
        chk("stall",       int'(bus.out_stall),       mon_e.stall);
        chk("idex_bubble", int'(bus.out_idex_bubble), mon_e.bubble);
        chk("mc_full",     int'(bus.out_mc_full),     mon_e.full);
        chk("stall_count", int'(bus.out_stall_count), mon_e.cnt);
      end
      $display("txn %0d rst=%0d a=%0d b=%0d wd=%0d stall=%0d bubble=%0d full=%0d count=%0d",
               txn, rst, bus.out_forwarda_sel, bus.out_forwardb_sel, bus.out_forwardwd_sel,
               bus.out_stall, bus.out_idex_bubble, bus.out_mc_full, bus.out_stall_count);
      txn++;
    end
  end

  function automatic int fsel(input int src, input bit use_src);
    if (use_src && bus.in_exmem_regwrite && bus.in_exmem_rd != 0 && int'(bus.in_exmem_rd) == src)
      return 2;
    if (use_src && bus.in_memwb_regwrite && bus.in_memwb_rd != 0 && int'(bus.in_memwb_rd) == src)
      return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    bus.in_ifid_rs1 = '0;       bus.in_ifid_rs2 = '0;
    bus.in_ifid_use_rs1 = 1'b0; bus.in_ifid_use_rs2 = 1'b0;
    bus.in_ifid_is_mc = 1'b0;
    bus.in_idex_rs1 = '0;       bus.in_idex_rs2 = '0;       bus.in_idex_rd = '0;
    bus.in_idex_use_rs1 = 1'b0; bus.in_idex_use_rs2 = 1'b0;
    bus.in_idex_is_store = 1'b0; bus.in_idex_memread = 1'b0; bus.in_idex_regwrite = 1'b0;
    bus.in_exmem_regwrite = 1'b0; bus.in_memwb_regwrite = 1'b0;
    bus.in_exmem_rd = '0;       bus.in_memwb_rd = '0;
    bus.in_mc_issue = 1'b0;     bus.in_mc_rd = '0;
    bus.in_mc_done = 1'b0;      bus.in_mc_done_rd = '0;
  endtask

  // Predict this cycle, queue it, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    int   r2, i1, i2, rd, mrd, drd;
    bit   hazard, stl, iss, dn;
    bit   pend_n[NREGS];
    int   out_n, lu_n, cnt_n;
    i1  = int'(bus.in_ifid_rs1);
    i2  = int'(bus.in_ifid_rs2);
    rd  = int'(bus.in_idex_rd);
    mrd = int'(bus.in_mc_rd);
    drd = int'(bus.in_mc_done_rd);
    e.fa = fsel(int'(bus.in_idex_rs1), bus.in_idex_use_rs1);
    r2   = fsel(int'(bus.in_idex_rs2), bus.in_idex_use_rs2);
    e.fb  = bus.in_idex_is_store ? 0 : r2;
    e.fwd = bus.in_idex_is_store ? r2 : 0;
    hazard = bus.in_idex_memread && bus.in_idex_regwrite && rd != 0 &&
             ((bus.in_ifid_use_rs1 && i1 == rd) || (bus.in_ifid_use_rs2 && i2 == rd));
    stl = (m_lu_left > 0) || hazard ||
          (bus.in_ifid_use_rs1 && m_pend[i1]) || (bus.in_ifid_use_rs2 && m_pend[i2]) ||
          (bus.in_ifid_is_mc && m_out == MAX_OUT);
    e.stall     = int'(stl);
    e.bubble    = int'(stl);
    e.full      = (m_out == MAX_OUT) ? 1 : 0;
    e.cnt       = m_cnt;
    e.chk_state = !rst;
    q.push_back(e);

    pend_n = m_pend;
    if (rst) begin
      foreach (pend_n[k]) pend_n[k] = 1'b0;
      out_n = 0; lu_n = 0; cnt_n = 0;
    end else begin
      lu_n  = (m_lu_left > 0) ? m_lu_left - 1 : (hazard ? LOAD_LAT - 1 : 0);
      iss   = bus.in_mc_issue && mrd != 0 && m_out < MAX_OUT;
      dn    = bus.in_mc_done && m_pend[drd];
      if (dn)  pend_n[drd] = 1'b0;
      if (iss) pend_n[mrd] = 1'b1;
      out_n = m_out + int'(iss) - int'(dn);
      cnt_n = (stl && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    end
    @(posedge clk);
    m_pend = pend_n; m_out = out_n; m_lu_left = lu_n; m_cnt = cnt_n;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d queued, txn %0d", q.size(), txn);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;

    // Forwarding priority and x0 suppression
    bus.in_exmem_regwrite = 1'b1; bus.in_exmem_rd = 5'd5;
    bus.in_memwb_regwrite = 1'b1; bus.in_memwb_rd = 5'd5;
    bus.in_idex_rs1 = 5'd5; bus.in_idex_use_rs1 = 1'b1;
    step();
    bus.in_exmem_regwrite = 1'b0; step();
    bus.in_exmem_regwrite = 1'b1; bus.in_exmem_rd = 5'd0; bus.in_memwb_rd = 5'd0; step();
    clear_inputs();

    // Store data routing
    bus.in_idex_rs2 = 5'd7; bus.in_idex_use_rs2 = 1'b1;
    bus.in_exmem_regwrite = 1'b1; bus.in_exmem_rd = 5'd7; bus.in_idex_is_store = 1'b1;
    step();
    bus.in_idex_is_store = 1'b0; step();
    clear_inputs();

    // Load-use: load advances out of ID/EX after the first stalled cycle
    bus.in_idex_memread = 1'b1; bus.in_idex_regwrite = 1'b1; bus.in_idex_rd = 5'd4;
    bus.in_ifid_rs2 = 5'd4; bus.in_ifid_use_rs2 = 1'b1;
    step();
    bus.in_idex_memread = 1'b0; bus.in_idex_regwrite = 1'b0;
    repeat (3) step();
    clear_inputs();

    // Multi-cycle dependency on x9
    bus.in_mc_issue = 1'b1; bus.in_mc_rd = 5'd9; step();
    clear_inputs();
    bus.in_ifid_rs1 = 5'd9; bus.in_ifid_use_rs1 = 1'b1;
    repeat (3) step();
    bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd9; step();
    bus.in_mc_done = 1'b0; step();
    clear_inputs(); step();

    // Outstanding limit
    bus.in_mc_issue = 1'b1; bus.in_mc_rd = 5'd10; step();
    bus.in_mc_rd = 5'd11; step();
    bus.in_mc_issue = 1'b0; bus.in_ifid_is_mc = 1'b1; step(); step();
    bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd10; step();
    bus.in_mc_done = 1'b0; step();
    bus.in_ifid_is_mc = 1'b0; bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd20; step();
    bus.in_mc_done = 1'b0; bus.in_mc_issue = 1'b1; bus.in_mc_rd = 5'd12; step();
    bus.in_mc_rd = 5'd13; bus.in_ifid_is_mc = 1'b1; step();
    clear_inputs();
    bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd11; step();
    bus.in_mc_done_rd = 5'd12; step();
    bus.in_mc_done = 1'b0; bus.in_ifid_rs1 = 5'd13; bus.in_ifid_use_rs1 = 1'b1; step();
    clear_inputs();

    // Reset during LU_WAIT with x3 pending
    bus.in_mc_issue = 1'b1; bus.in_mc_rd = 5'd3; step();
    clear_inputs();
    bus.in_idex_memread = 1'b1; bus.in_idex_regwrite = 1'b1; bus.in_idex_rd = 5'd4;
    bus.in_ifid_rs1 = 5'd4; bus.in_ifid_use_rs1 = 1'b1; step();
    clear_inputs(); step();
    rst = 1'b1; bus.in_ifid_rs1 = 5'd3; bus.in_ifid_use_rs1 = 1'b1; step();
    rst = 1'b0; step(); step();
    clear_inputs();

    // Simultaneous issue and done on x6
    bus.in_mc_issue = 1'b1; bus.in_mc_rd = 5'd6; step();
    bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd6; step();
    clear_inputs();
    bus.in_ifid_rs1 = 5'd6; bus.in_ifid_use_rs1 = 1'b1; step();
    bus.in_mc_done = 1'b1; bus.in_mc_done_rd = 5'd6; step();
    bus.in_mc_done = 1'b0; step();
    clear_inputs();

    // Randomized traffic over a small register window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      bus.in_ifid_rs1       = 5'($urandom_range(0, 7));
      bus.in_ifid_rs2       = 5'($urandom_range(0, 7));
      bus.in_ifid_use_rs1   = 1'($urandom_range(0, 1));
      bus.in_ifid_use_rs2   = 1'($urandom_range(0, 1));
      bus.in_ifid_is_mc     = ($urandom_range(0, 3) == 0);
      bus.in_idex_rs1       = 5'($urandom_range(0, 7));
      bus.in_idex_rs2       = 5'($urandom_range(0, 7));
      bus.in_idex_rd        = 5'($urandom_range(0, 7));
      bus.in_idex_use_rs1   = 1'($urandom_range(0, 1));
      bus.in_idex_use_rs2   = 1'($urandom_range(0, 1));
      bus.in_idex_is_store  = 1'($urandom_range(0, 1));
      bus.in_idex_memread   = ($urandom_range(0, 3) == 0);
      bus.in_idex_regwrite  = 1'($urandom_range(0, 1));
      bus.in_exmem_regwrite = 1'($urandom_range(0, 1));
      bus.in_memwb_regwrite = 1'($urandom_range(0, 1));
      bus.in_exmem_rd       = 5'($urandom_range(0, 7));
      bus.in_memwb_rd       = 5'($urandom_range(0, 7));
      bus.in_mc_issue       = ($urandom_range(0, 2) == 0);
      bus.in_mc_rd          = 5'($urandom_range(0, 7));
      bus.in_mc_done        = ($urandom_range(0, 2) == 0);
      bus.in_mc_done_rd     = 5'($urandom_range(0, 7));
      rst                   = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (4) step();

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's forwarding logic. Combines EX/MEM and MEM/WB operand forwarding (ALU operands and store data) with load-use stall sequencing.
- Adds a scoreboard of pending writes from multi-cycle units (mul/div, long-latency loads) and a saturating stall-cycle counter.
- Sits between decode (IF/ID) and execute (ID/EX). Drives the operand muxes, PC/IF-ID hold, and ID/EX bubble insertion.

Parameters:
- RW, 5, register address width.
- NREGS, 32, register count (≤ 2^RW); index 0 is hard zero.
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7).
- MAX_OUT, 4, maximum outstanding multi-cycle ops (1..15).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_ifid_rs1, in_ifid_rs2  in  RW  decode-stage source registers.
- in_ifid_use_rs1, in_ifid_use_rs2  in  1  decode instruction reads rs1/rs2.
- in_ifid_is_mc  in  1  decode instruction is multi-cycle.
- in_idex_rs1, in_idex_rs2, in_idex_rd  in  RW  execute-stage registers.
- in_idex_use_rs1, in_idex_use_rs2  in  1  execute instruction reads rs1/rs2.
- in_idex_is_store, in_idex_memread, in_idex_regwrite  in  1  execute-stage control.
- in_exmem_regwrite, in_memwb_regwrite  in  1  later-stage write enables.
- in_exmem_rd, in_memwb_rd  in  RW  later-stage destinations.
- in_mc_issue  in  1  multi-cycle op leaves decode this cycle.
- in_mc_rd  in  RW  destination of the issuing op.
- in_mc_done  in  1  multi-cycle op writes back this cycle.
- in_mc_done_rd  in  RW  destination of the completing op.
- out_forwarda_sel, out_forwardb_sel, out_forwardwd_sel  out  2  00 = regfile, 01 = MEM/WB, 10 = EX/MEM.
- out_stall  out  1  hold PC and IF/ID.
- out_idex_bubble  out  1  load NOP into ID/EX.
- out_mc_full  out  1  outstanding count == MAX_OUT.
- out_stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding is combinational, zero latency.
- A source matches stage S when: S regwrite = 1, S rd != 0, S rd == source, and the matching use flag = 1. EX/MEM has priority over MEM/WB.
- forwarda_sel: rs1 match result.
- rs2 match result goes to forwardwd_sel when in_idex_is_store = 1 (forwardb_sel = 00). Otherwise it goes to forwardb_sel (forwardwd_sel = 00).
- Load-use hazard: in_idex_memread & in_idex_regwrite & in_idex_rd != 0 & in_idex_rd matches a used IF/ID source.
- FSM states: IDLE, LU_WAIT. 3-bit down-counter lu_cnt.
  - IDLE: on load-use hazard, assert stall and bubble this cycle. If LOAD_LAT > 1, go to LU_WAIT with lu_cnt = LOAD_LAT-1; otherwise stay in IDLE.
  - LU_WAIT: assert stall and bubble; decrement lu_cnt. Go to IDLE at the edge where lu_cnt == 1. The load-use check is ignored while in LU_WAIT.
- Scoreboard: pend[NREGS-1:0] plus an outstanding counter out_cnt.
  - in_mc_issue with in_mc_rd != 0 sets pend[in_mc_rd] and increments out_cnt.
  - in_mc_done clears pend[in_mc_done_rd] and decrements out_cnt, only if that bit was set. A done for a non-pending register or x0 is ignored.
  - Same-cycle issue and done to the same register: bit stays set, out_cnt unchanged.
  - pend[0] is always 0.
- Scoreboard stall: asserted in any state when any used IF/ID source is pending, or when in_ifid_is_mc & out_mc_full. Same cycle; also asserts out_idex_bubble.
- A done in cycle N clears the bit at edge N; the dependent instruction un-stalls in cycle N+1. Same-cycle bypass of the mc result is handled by MEM/WB forwarding upstream, not here.
- Issue while out_cnt == MAX_OUT (protocol violation): ignored, no state change.
- out_stall_count increments each cycle out_stall = 1 and saturates at all-ones.
- Reset (synchronous, any point including mid-stall) sets:
  - FSM = IDLE, lu_cnt = 0, pend = 0, out_cnt = 0, out_stall_count = 0.
  - out_stall, out_idex_bubble and out_mc_full to 0 on the following cycle.
- Select outputs remain combinational through reset.

Test Plan:
- EX/MEM rd = 5 regwrite, MEM/WB rd = 5 regwrite, idex rs1 = 5 use = 1 -> forwarda_sel = 10. Drop exmem_regwrite -> 01. rd = 0 -> 00.
- Store with idex rs2 = 7, exmem rd = 7 -> forwardwd_sel = 10, forwardb_sel = 00. Same inputs with is_store = 0 -> forwardb_sel = 10, wd = 00.
- LOAD_LAT = 3, idex load rd = 4, ifid rs2 = 4 use = 1 -> stall/bubble high exactly 3 cycles, then IDLE. out_stall_count = 3.
- Issue mc rd = 9. Next cycle ifid rs1 = 9 -> stall held until the done cycle, drops the cycle after. out_cnt returns to 0.
- MAX_OUT = 2: two issues -> out_mc_full = 1. ifid_is_mc -> stall. One done -> full = 0 and stall releases next cycle. Done to a non-pending reg -> out_cnt unchanged.
- rst asserted during LU_WAIT with pend[3] set -> next cycle stall = 0, pend = 0, counter = 0. Simultaneous issue/done on rd = 6 -> pend[6] stays 1.
